// File: rtl/spike_packet_encoder_pkg.sv
// Shared NoC definitions for the spike packet encoder: packet field widths,
// type codes, encoder FSM states and the packet assembly helper.
package spike_packet_encoder_pkg;

   localparam int TYPE_W = 2;
   localparam int NODE_W = 6;
   localparam int NEUR_W = 8;
   localparam int TS_W   = 16;
   localparam int PKT_W  = TYPE_W + NODE_W + NEUR_W + TS_W;

   localparam logic [TYPE_W-1:0] PKT_SPIKE = 2'b01;
   localparam logic [TYPE_W-1:0] PKT_EOT   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_EOT    = 2'b10
   } enc_state_e;

   function automatic logic [PKT_W-1:0] make_pkt(
      input logic [TYPE_W-1:0] typ,
      input logic [NODE_W-1:0] node,
      input logic [NEUR_W-1:0] neuron,
      input logic [TS_W-1:0]   ts
   );
      return {typ, node, neuron, ts};
   endfunction

endpackage

// File: rtl/spike_packet_encoder_pkt_fifo.sv
// Packet queue: power-of-two depth, flop storage, head word read straight from
// the storage flops, and push accepted on a full queue when a pop happens too.
module pkt_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == {(AW+1){1'b0}});
   assign head  = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue state registers; storage cleared so the head word reads zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/spike_packet_encoder.sv
// Spike packet encoder: turns per-neuron spike results of a timestep into NoC
// packets, closes each timestep with an end-of-timestep packet, queues them for the router.
module spike_packet_encoder
   import spike_packet_encoder_pkg::*;
#(
   parameter logic [NODE_W-1:0] NODE_ID    = 6'd0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ts_start,
   input  logic              ts_end,
   input  logic              res_valid,
   input  logic              res_spike,
   input  logic [NEUR_W-1:0] res_neuron,
   output logic              pkt_valid,
   input  logic              pkt_ready,
   output logic [PKT_W-1:0]  pkt_data,
   output logic              busy,
   output logic [7:0]        drop_count
);

   enc_state_e        state_q, state_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [7:0]        drop_q, drop_d;
   logic              busy_q, busy_d;
   logic [1:0]        rst_sync_q, rst_sync_d;

   logic              fifo_push_s;
   logic [PKT_W-1:0]  fifo_data_s;
   logic              fifo_pop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [PKT_W-1:0]  fifo_head_s;
   logic              room_s;
   logic              spike_s;

   pkt_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push_s),
      .push_data (fifo_data_s),
      .pop       (fifo_pop_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   assign pkt_valid  = !fifo_empty_s;
   assign pkt_data   = fifo_head_s;
   assign fifo_pop_s = !fifo_empty_s && pkt_ready;
   assign busy       = busy_q;
   assign drop_count = drop_q;
   assign rst_sync_d = {rst_sync_q[0], 1'b1};

   // FSM next state, packet assembly, drop accounting.
   always_comb begin
      state_d     = state_q;
      ts_d        = ts_q;
      drop_d      = drop_q;
      fifo_push_s = 1'b0;
      fifo_data_s = {PKT_W{1'b0}};
      spike_s     = res_valid && res_spike;
      // A full queue still takes a word when the router drains one this cycle.
      room_s      = !fifo_full_s || fifo_pop_s;
      case (state_q)
         ST_IDLE: begin
            if (ts_start && rst_sync_q[1]) begin
               state_d = ST_ACTIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            fifo_data_s = make_pkt(PKT_SPIKE, NODE_ID, res_neuron, ts_q);
            if (spike_s && room_s) begin
               fifo_push_s = 1'b1;
            end else if (spike_s && (drop_q != 8'hFF)) begin
               drop_d = drop_q + 8'd1;
            end else begin
               drop_d = drop_q;
            end
            if (ts_end) begin
               state_d = ST_EOT;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_EOT: begin
            fifo_data_s = make_pkt(PKT_EOT, NODE_ID, 8'h00, ts_q);
            if (room_s) begin
               fifo_push_s = 1'b1;
               state_d     = ST_IDLE;
               ts_d        = ts_q + 16'd1;
            end else begin
               state_d = ST_EOT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Control registers; rst_sync_q gates leaving IDLE until reset release has been seen by clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ts_q       <= 16'h0000;
         drop_q     <= 8'h00;
         busy_q     <= 1'b0;
         rst_sync_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         drop_q     <= drop_d;
         busy_q     <= busy_d;
         rst_sync_q <= rst_sync_d;
      end
   end

endmodule

// File: tb/tb_spike_packet_encoder.sv
// Self-checking bench for spike_packet_encoder: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_spike_packet_encoder;

   localparam int         DEPTH = 4;
   localparam logic [5:0] NID   = 6'd0;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        ts_start   = 1'b0;
   logic        ts_end     = 1'b0;
   logic        res_valid  = 1'b0;
   logic        res_spike  = 1'b0;
   logic [7:0]  res_neuron = 8'h00;
   logic        pkt_ready  = 1'b0;
   logic        pkt_valid;
   logic [31:0] pkt_data;
   logic        busy;
   logic [7:0]  drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: packet queue, phase (0 idle, 1 active, 2 eot), timestep, drops
   logic [31:0] mq[$];
   logic [31:0] got[$];
   int          phase;
   logic [15:0] m_ts;
   int          m_drop;
   int          since_rst;

   always #5 clk = ~clk;

   spike_packet_encoder #(
      .NODE_ID    (NID),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ts_start   (ts_start),
      .ts_end     (ts_end),
      .res_valid  (res_valid),
      .res_spike  (res_spike),
      .res_neuron (res_neuron),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_data   (pkt_data),
      .busy       (busy),
      .drop_count (drop_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      if (i < got.size()) return got[i];
      else return 32'hDEAD_BEEF;
   endfunction

   task automatic model_reset();
      mq.delete();
      phase     = 0;
      m_ts      = 16'h0000;
      m_drop    = 0;
      since_rst = 0;
   endtask

   // One clock cycle: apply inputs at negedge, step model at posedge, check at next negedge.
   task automatic cyc(input bit s, input bit e, input bit v, input bit sp,
                      input logic [7:0] n, input bit rdy);
      bit          pop;
      bit          room;
      bit          stall;
      logic [31:0] held;
      ts_start   = s;
      ts_end     = e;
      res_valid  = v;
      res_spike  = sp;
      res_neuron = n;
      pkt_ready  = rdy;
      stall      = pkt_valid && !rdy;
      held       = pkt_data;
      if (pkt_valid && rdy) got.push_back(pkt_data);
      @(posedge clk);
      pop  = (mq.size() > 0) && rdy;
      room = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      case (phase)
         0: if (s && since_rst >= 2) phase = 1;
         1: begin
            if (v && sp) begin
               if (room) mq.push_back({2'b01, NID, n, m_ts});
               else if (m_drop < 255) m_drop++;
            end
            if (e) phase = 2;
         end
         default: begin
            if (room) begin
               mq.push_back({2'b10, NID, 8'h00, m_ts});
               m_ts  = m_ts + 16'd1;
               phase = 0;
            end
         end
      endcase
      since_rst++;
      @(negedge clk);
      check_eq("pkt_valid", 32'(pkt_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check_eq("pkt_data", pkt_data, mq[0]);
      check_eq("busy", 32'(busy), 32'(phase != 0));
      check_eq("drop_count", 32'(drop_count), 32'(m_drop));
      if (stall) begin
         check_eq("hold_valid", 32'(pkt_valid), 32'd1);
         check_eq("hold_data", pkt_data, held);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_pkt_valid", 32'(pkt_valid), 32'd0);
      check_eq("rst_pkt_data", pkt_data, 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_drop_count", 32'(drop_count), 32'd0);
      model_reset();
      got.delete();
      ts_start  = 1'b0;
      ts_end    = 1'b0;
      res_valid = 1'b0;
      res_spike = 1'b0;
      pkt_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      model_reset();
      do_reset();
      // ts_start right after reset release must be ignored
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      drain(3);

      // basic timestep with two spikes
      got.delete();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      drain(4);
      check_eq("basic_count", 32'(got.size()), 32'd3);
      check_eq("basic_pkt0", got_at(0), 32'h4003_0000);
      check_eq("basic_pkt1", got_at(1), 32'h4007_0000);
      check_eq("basic_eot", got_at(2), 32'h8000_0000);
      got.delete();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd9, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      drain(4);
      check_eq("ts1_spike", got_at(0), 32'h4009_0001);
      check_eq("ts1_eot", got_at(1), 32'h8000_0001);

      // overflow: router stalled, six spikes into a four-deep queue
      got.delete();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'(16 + i), 1'b0);
      check_eq("ovf_drop", 32'(drop_count), 32'd2);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("ovf_eot_stall", 32'(busy), 32'd1);
      drain(8);
      check_eq("ovf_count", 32'(got.size()), 32'd5);
      check_eq("ovf_first", got_at(0), 32'h4010_0002);
      check_eq("ovf_eot_last", got_at(4), 32'h8000_0002);

      // timestep wrap
      force dut.ts_q = 16'hFFFF;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      release dut.ts_q;
      m_ts = 16'hFFFF;
      got.delete();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      drain(3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h23, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      drain(3);
      check_eq("wrap_spike", got_at(0), 32'h4022_FFFF);
      check_eq("wrap_eot", got_at(1), 32'h8000_FFFF);
      check_eq("wrap_next", got_at(2), 32'h4023_0000);

      // same-cycle start/end in IDLE, non-spike results, spike with ts_end, strays outside ACTIVE
      got.delete();
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1);
      drain(3);
      check_eq("edge_count", 32'(got.size()), 32'd2);
      check_eq("edge_spike", got_at(0), 32'h4044_0001);
      check_eq("edge_eot", got_at(1), 32'h8000_0001);

      // random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 8) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
             ($urandom % 3) != 0, 8'($urandom), ($urandom % 2) == 1);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      drain(6);

      // reset with packets queued mid-timestep
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'(40 + i), 1'b0);
      check_eq("pre_rst_valid", 32'(pkt_valid), 32'd1);
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      drain(3);
      check_eq("post_rst_busy", 32'(busy), 32'd0);
      check_eq("post_rst_drop", 32'(drop_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
